// File: rtl/apb_arb_master.sv
// Two-requester APB3 master: round-robin arbitration between two request ports,
// one SETUP/ACCESS transfer at a time, with a wait-state watchdog abort.
module apb_arb_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_done,
    output logic [DW-1:0] req0_rdata,
    output logic          req0_err,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_done,
    output logic [DW-1:0] req1_rdata,
    output logic          req1_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          r_state;
    logic            r_owner;
    logic            r_ptr;
    logic [CW-1:0]   r_waitCnt;

    state_t          w_nextState;
    logic            w_owner;
    logic            w_ptr;
    logic [CW-1:0]   w_waitCnt;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_grant;
    logic            w_finish;
    logic            w_finErr;
    logic [DW-1:0]   w_finData;
    logic            w_psel;
    logic            w_penable;
    logic            w_pwrite;
    logic [AW-1:0]   w_paddr;
    logic [DW-1:0]   w_pwdata;
    logic            w_done0;
    logic            w_done1;
    logic            w_err0;
    logic            w_err1;
    logic [DW-1:0]   w_rdata0;
    logic [DW-1:0]   w_rdata1;

    // A requester whose done pulse is showing this cycle is not re-granted,
    // which hands the bus to the other side and enforces the 3-cycle spacing.
    assign w_elig0 = req0_valid & ~req0_done;
    assign w_elig1 = req1_valid & ~req1_done;

    always_comb begin
        w_nextState = r_state;
        w_owner     = r_owner;
        w_ptr       = r_ptr;
        w_waitCnt   = r_waitCnt;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_finErr    = 1'b0;
        w_finData   = '0;
        w_psel      = PSEL;
        w_penable   = PENABLE;
        w_pwrite    = PWRITE;
        w_paddr     = PADDR;
        w_pwdata    = PWDATA;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        w_err0      = 1'b0;
        w_err1      = 1'b0;
        w_rdata0    = '0;
        w_rdata1    = '0;

        case (r_state)
            IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_grant     = (w_elig0 & w_elig1) ? r_ptr : w_elig1;
                    w_owner     = w_grant;
                    w_pwrite    = w_grant ? req1_write : req0_write;
                    w_paddr     = w_grant ? req1_addr  : req0_addr;
                    w_pwdata    = w_grant ? req1_wdata : req0_wdata;
                    w_psel      = 1'b1;
                    w_penable   = 1'b0;
                    w_waitCnt   = '0;
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                w_penable   = 1'b1;
                w_nextState = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_finish  = 1'b1;
                    w_finErr  = PSLVERR;
                    w_finData = PWRITE ? '0 : PRDATA;
                end else if ((TIMEOUT != 0) && (r_waitCnt == LAST_WAIT)) begin
                    w_finish  = 1'b1;
                    w_finErr  = 1'b1;
                    w_finData = '0;
                end else begin
                    w_waitCnt = r_waitCnt + CW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        // Completion (normal or watchdog) releases the bus and flips priority.
        if (w_finish) begin
            w_psel      = 1'b0;
            w_penable   = 1'b0;
            w_ptr       = ~r_owner;
            w_nextState = IDLE;
            w_done0     = ~r_owner;
            w_done1     = r_owner;
            w_err0      = ~r_owner & w_finErr;
            w_err1      = r_owner & w_finErr;
            w_rdata0    = r_owner ? '0 : w_finData;
            w_rdata1    = r_owner ? w_finData : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_ptr      <= 1'b0;
            r_waitCnt  <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_done  <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= '0;
            req1_done  <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= '0;
        end else begin
            r_state    <= w_nextState;
            r_owner    <= w_owner;
            r_ptr      <= w_ptr;
            r_waitCnt  <= w_waitCnt;
            PSEL       <= w_psel;
            PENABLE    <= w_penable;
            PWRITE     <= w_pwrite;
            PADDR      <= w_paddr;
            PWDATA     <= w_pwdata;
            req0_done  <= w_done0;
            req0_err   <= w_err0;
            req0_rdata <= w_rdata0;
            req1_done  <= w_done1;
            req1_err   <= w_err1;
            req1_rdata <= w_rdata1;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_apb_arb_master;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_done, req0_err, req1_done, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int vectors     = 0;
    int miscompares = 0;

    apb_arb_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: one outstanding transfer, round-robin pick, outcome
    // decided by how many ACCESS cycles elapsed and what the slave answered.
    logic          mBusy, mInAccess, mOwner, mWrite, mPtr;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata;
    int            mWaits;
    logic [1:0]    eDone, eErr;
    logic [DW-1:0] eRdata0, eRdata1;

    wire mElig0 = req0_valid && !eDone[0];
    wire mElig1 = req1_valid && !eDone[1];
    wire mWin   = (mElig0 && mElig1) ? mPtr : mElig1;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mBusy <= 1'b0; mInAccess <= 1'b0; mOwner <= 1'b0; mWrite <= 1'b0;
            mPtr <= 1'b0; mAddr <= '0; mWdata <= '0; mWaits <= 0;
            eDone <= '0; eErr <= '0; eRdata0 <= '0; eRdata1 <= '0;
        end else begin
            eDone <= '0; eErr <= '0; eRdata0 <= '0; eRdata1 <= '0;
            if (!mBusy) begin
                if (mElig0 || mElig1) begin
                    mBusy     <= 1'b1;
                    mInAccess <= 1'b0;
                    mWaits    <= 0;
                    mOwner    <= mWin;
                    mWrite    <= mWin ? req1_write : req0_write;
                    mAddr     <= mWin ? req1_addr  : req0_addr;
                    mWdata    <= mWin ? req1_wdata : req0_wdata;
                end
            end else if (!mInAccess) begin
                mInAccess <= 1'b1;
            end else if (PREADY || (TIMEOUT != 0 && mWaits + 1 == TIMEOUT)) begin
                mBusy          <= 1'b0;
                mPtr           <= !mOwner;
                eDone[mOwner]  <= 1'b1;
                eErr[mOwner]   <= PREADY ? PSLVERR : 1'b1;
                if (PREADY && !mWrite) begin
                    if (mOwner) eRdata1 <= PRDATA;
                    else        eRdata0 <= PRDATA;
                end
            end else begin
                mWaits <= mWaits + 1;
            end
        end
    end

    always @(negedge PCLK) begin
        checkOutput("psel", 64'(PSEL), 64'(mBusy));
        checkOutput("penable", 64'(PENABLE), 64'(mBusy && mInAccess));
        if (mBusy) begin
            checkOutput("pwrite", 64'(PWRITE), 64'(mWrite));
            checkOutput("paddr", 64'(PADDR), 64'(mAddr));
            checkOutput("pwdata", 64'(PWDATA), 64'(mWdata));
        end
        checkOutput("req0_done", 64'(req0_done), 64'(eDone[0]));
        checkOutput("req1_done", 64'(req1_done), 64'(eDone[1]));
        checkOutput("req0_err", 64'(req0_err), 64'(eErr[0]));
        checkOutput("req1_err", 64'(req1_err), 64'(eErr[1]));
        checkOutput("req0_rdata", 64'(req0_rdata), 64'(eRdata0));
        checkOutput("req1_rdata", 64'(req1_rdata), 64'(eRdata1));
    end

    task automatic applyStimulus(input int who, input logic valid, input logic write,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        @(negedge PCLK);
        if (who == 0) begin
            req0_valid = valid; req0_write = write; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = valid; req1_write = write; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    // Waits at negedges for the requester's done pulse; an expired budget is a failure.
    task automatic waitDone(input int who, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge PCLK);
            cycles++;
            if ((who == 0 && req0_done) || (who == 1 && req1_done)) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL doneTimeout: requester %0d got no done within %0d cycles expected a done pulse", who, budget);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation still running expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int pselCnt, penCnt, doneCnt, cyc;
        logic [AW-1:0] grants[$];
        logic seenDone;

        PRESETn = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        checkOutput("resetPsel", 64'(PSEL), 64'd0);
        checkOutput("resetDone", 64'({req0_done, req1_done}), 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        $display("[TB] scenario 1: req0 zero-wait write");
        applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_0001);
        pselCnt = 0; penCnt = 0; doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if (PSEL) begin
                pselCnt++;
                checkOutput("t1Pwdata", 64'(PWDATA), 64'h0000_0000_A5A5_0001);
            end
            if (PENABLE) penCnt++;
            if (req0_done) begin
                doneCnt++;
                checkOutput("t1Err", 64'(req0_err), 64'd0);
                req0_valid = 1'b0;
            end
        end
        checkOutput("t1PselCycles", 64'(pselCnt), 64'd2);
        checkOutput("t1PenableCycles", 64'(penCnt), 64'd1);
        checkOutput("t1DonePulses", 64'(doneCnt), 64'd1);

        $display("[TB] scenario 2: req1 read with two wait states");
        PREADY = 1'b0; PRDATA = 32'h1111_1111;
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
        penCnt = 0; doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            if (PSEL) checkOutput("t2Paddr", 64'(PADDR), 64'h20);
            if (PENABLE) begin
                penCnt++;
                if (penCnt == 3) begin
                    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
                end
            end
            if (req1_done) begin
                doneCnt++;
                checkOutput("t2Rdata", 64'(req1_rdata), 64'h0000_0000_DEAD_BEEF);
                checkOutput("t2Req0Done", 64'(req0_done), 64'd0);
                req1_valid = 1'b0;
                PRDATA = 32'h2222_2222;
            end
        end
        checkOutput("t2AccessCycles", 64'(penCnt), 64'd3);
        checkOutput("t2DonePulses", 64'(doneCnt), 64'd1);

        $display("[TB] scenario 3: both requesters held valid");
        @(negedge PCLK);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h100; req0_wdata = 32'h0000_0100;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h200; req1_wdata = 32'h0000_0200;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) grants.push_back(PADDR);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) @(negedge PCLK);
        checkOutput("t3GrantCount", 64'(grants.size()), 64'd4);
        if (grants.size() >= 4) begin
            checkOutput("t3Grant0", 64'(grants[0]), 64'h100);
            checkOutput("t3Grant1", 64'(grants[1]), 64'h200);
            checkOutput("t3Grant2", 64'(grants[2]), 64'h100);
            checkOutput("t3Grant3", 64'(grants[3]), 64'h200);
        end

        $display("[TB] scenario 4: PREADY stuck low, watchdog abort");
        PREADY = 1'b0; PRDATA = 32'hCAFE_0000;
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
        penCnt = 0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge PCLK);
            cyc++;
            if (PENABLE) penCnt++;
            if (req0_done) break;
        end
        checkOutput("t4DoneSeen", 64'(req0_done), 64'd1);
        checkOutput("t4AccessCycles", 64'(penCnt), 64'd16);
        checkOutput("t4Err", 64'(req0_err), 64'd1);
        checkOutput("t4Rdata", 64'(req0_rdata), 64'd0);
        checkOutput("t4PselAfter", 64'(PSEL), 64'd0);
        req0_valid = 1'b0;
        @(negedge PCLK);
        checkOutput("t4BusIdle", 64'({PSEL, PENABLE}), 64'd0);
        PREADY = 1'b1;

        $display("[TB] scenario 5: slave error on write");
        PSLVERR = 1'b1;
        applyStimulus(1, 1'b1, 1'b1, 32'h70, 32'h7777_0007);
        waitDone(1, 10, cyc);
        checkOutput("t5Err", 64'(req1_err), 64'd1);
        checkOutput("t5Rdata", 64'(req1_rdata), 64'd0);
        checkOutput("t5Req0Done", 64'(req0_done), 64'd0);
        req1_valid = 1'b0;
        PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);

        $display("[TB] scenario 6: reset during ACCESS");
        applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'h0000_1234);
        waitDone(0, 10, cyc);
        req0_valid = 1'b0;
        PREADY = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 32'h50, 32'h0);
        cyc = 0;
        while (cyc < 10 && !PENABLE) begin
            @(negedge PCLK);
            cyc++;
        end
        checkOutput("t6ReachedAccess", 64'(PENABLE), 64'd1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("t6PselReset", 64'(PSEL), 64'd0);
        checkOutput("t6PenableReset", 64'(PENABLE), 64'd0);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h60; req0_wdata = '0;
        @(negedge PCLK);
        checkOutput("t6NoDoneInReset", 64'(req1_done), 64'd0);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        seenDone = 1'b0;
        cyc = 0;
        while (cyc < 6 && !(PSEL && !PENABLE)) begin
            @(negedge PCLK);
            cyc++;
            if (req1_done) seenDone = 1'b1;
        end
        checkOutput("t6FirstGrantAddr", 64'(PADDR), 64'h60);
        checkOutput("t6NoAbortedDone", 64'(seenDone), 64'd0);
        waitDone(0, 10, cyc);
        req0_valid = 1'b0;
        waitDone(1, 10, cyc);
        req1_valid = 1'b0;
        repeat (4) @(negedge PCLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
